// File: rtl/vz16_bus_if.sv
// vz16_bus_if: vz16 core bus between core (master) and memory responder (slave).
// bus_err exists only when VZ16_BUS_ERR_EN is defined.
interface vz16_bus_if;
  logic [4:0]  ControlBus;
  logic [15:0] addrBus;
  logic [15:0] dataOutBus;
  logic [15:0] instrBus;
  logic [15:0] dataInBus;
  logic        ready;
`ifdef VZ16_BUS_ERR_EN
  logic        bus_err;
  modport master (output ControlBus, addrBus, dataOutBus, input instrBus, dataInBus, ready, bus_err);
  modport slave  (input ControlBus, addrBus, dataOutBus, output instrBus, dataInBus, ready, bus_err);
`else
  modport master (output ControlBus, addrBus, dataOutBus, input instrBus, dataInBus, ready);
  modport slave  (input ControlBus, addrBus, dataOutBus, output instrBus, dataInBus, ready);
`endif
endinterface

// File: rtl/vz16_bus_responder.sv
// vz16_bus_responder: word-RAM bus responder with programmable wait states and one-cycle ready pulse.
// Optional VZ16_BUS_ERR_EN adds bus_err for out-of-range addresses and reserved ops.
module vz16_bus_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input logic        clk,
  input logic        reset,
  vz16_bus_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  localparam logic [3:0] WS_INIT  = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [1:0]            op_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [15:0]           wdat_q, instr_q, instr_d, din_q, din_d, rd, wr;
  logic                  bm_q, bs_q, err, ld, we;
  logic [15:0]           mem [2**DEPTH_LOG2];

  assign ld = state_q == IDLE && bus.ControlBus[0];

`ifdef VZ16_BUS_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) err_q <= 1'b0;
    else if (ld) err_q <= bus.ControlBus[2:1] == 2'b11 || (bus.addrBus >> DEPTH_LOG2) != 16'd0;
  assign err         = err_q;
  assign bus.bus_err = state_q == DONE && err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      bm_q    <= 1'b0;
      bs_q    <= 1'b0;
      instr_q <= NOP_INSTR;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      din_q   <= din_d;
      if (ld) begin
        op_q   <= bus.ControlBus[2:1];
        bm_q   <= bus.ControlBus[3];
        bs_q   <= bus.ControlBus[4];
        addr_q <= bus.addrBus[DEPTH_LOG2-1:0];
        wdat_q <= bus.dataOutBus;
      end
    end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = ld ? (WAIT_STATES > 0 ? WAIT : ACCESS) : IDLE;
      WAIT:    state_d = cnt_q == 4'd0 ? ACCESS : WAIT;
      ACCESS:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Read path is shared by fetch/read results and the byte-lane merge for writes.
  always_comb begin
    cnt_d   = ld ? WS_INIT : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    rd      = mem[addr_q];
    instr_d = (state_q == ACCESS && op_q == OP_FETCH) ? (err ? 16'hDEAD : rd) : instr_q;
    din_d   = (state_q == ACCESS && op_q == OP_READ)
              ? (err ? 16'hDEAD : bm_q ? {8'h00, bs_q ? rd[15:8] : rd[7:0]} : rd) : din_q;
    we      = state_q == ACCESS && op_q == OP_WRITE && !err;
    wr      = !bm_q ? wdat_q : bs_q ? {wdat_q[7:0], rd[7:0]} : {rd[15:8], wdat_q[7:0]};
  end

  always_ff @(posedge clk)
    if (we) mem[addr_q] <= wr;

  assign bus.instrBus  = instr_q;
  assign bus.dataInBus = din_q;
  assign bus.ready     = state_q == DONE;
endmodule

// File: tb/tb_vz16_bus_responder.sv
// tb_vz16_bus_responder: directed plus randomized checks of vz16_bus_responder against a word-array model.
// Two instances: u0 with one wait state, u1 with three wait states.
module tb_vz16_bus_responder;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  int   ncmp = 0;
  int   nfail = 0;
  logic [15:0] m [2][1024];
  logic [15:0] exp_i [2];
  logic [15:0] exp_d [2];

  vz16_bus_if if0 ();
  vz16_bus_if if1 ();

  vz16_bus_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1), .NOP_INSTR(16'h0000))
    u0 (.clk(clk), .reset(rst0), .bus(if0));
  vz16_bus_responder #(.DEPTH_LOG2(10), .WAIT_STATES(3), .NOP_INSTR(16'h0000))
    u1 (.clk(clk), .reset(rst1), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic [4:0] c, input logic [15:0] a, input logic [15:0] w);
    if (d == 0) begin
      if0.ControlBus = c; if0.addrBus = a; if0.dataOutBus = w;
    end else begin
      if1.ControlBus = c; if1.addrBus = a; if1.dataOutBus = w;
    end
  endtask

  function automatic logic rdy(input int d);
    return d != 0 ? if1.ready : if0.ready;
  endfunction
  function automatic logic [15:0] instr_of(input int d);
    return d != 0 ? if1.instrBus : if0.instrBus;
  endfunction
  function automatic logic [15:0] din_of(input int d);
    return d != 0 ? if1.dataInBus : if0.dataInBus;
  endfunction
`ifdef VZ16_BUS_ERR_EN
  function automatic logic berr(input int d);
    return d != 0 ? if1.bus_err : if0.bus_err;
  endfunction
`endif

  // One complete transaction: issue, wait for ready (bounded), update the model, compare.
  task automatic do_op(input int d, input logic [1:0] op, input logic bm, input logic bs,
                       input logic [15:0] a, input logic [15:0] w);
    int n;
    bit got;
    bit e;
    int idx;
    logic [15:0] old;
    idx = int'(a[9:0]);
    e = 1'b0;
`ifdef VZ16_BUS_ERR_EN
    e = a >= 16'd1024 || op == 2'b11;
`endif
    @(negedge clk);
    drive(d, {bs, bm, op, 1'b1}, a, w);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      got = rdy(d);
    end
    drive(d, 5'd0, 16'($urandom), 16'($urandom));
    chk("latency", 16'(n), 16'((d != 0 ? 3 : 1) + 2));
    old = m[d][idx];
    if (op == 2'b00) exp_i[d] = e ? 16'hDEAD : old;
    else if (op == 2'b01) exp_d[d] = e ? 16'hDEAD : bm ? {8'h00, bs ? old[15:8] : old[7:0]} : old;
    else if (op == 2'b10 && !e) m[d][idx] = bm ? (bs ? {w[7:0], old[7:0]} : {old[15:8], w[7:0]}) : w;
    chk("instrBus", instr_of(d), exp_i[d]);
    chk("dataInBus", din_of(d), exp_d[d]);
`ifdef VZ16_BUS_ERR_EN
    chk("bus_err", 16'(berr(d)), 16'(e));
`endif
    @(posedge clk);
    #1;
    chk("ready_width", 16'(rdy(d)), 16'd0);
  endtask

  initial begin
    drive(0, 5'd0, 16'd0, 16'd0);
    drive(1, 5'd0, 16'd0, 16'd0);
    exp_i = '{16'h0000, 16'h0000};
    exp_d = '{16'h0000, 16'h0000};
    // Reset held with random bus activity
    repeat (8) begin
      @(negedge clk);
      drive(0, 5'($urandom), 16'($urandom), 16'($urandom));
      drive(1, 5'($urandom), 16'($urandom), 16'($urandom));
      @(posedge clk);
      #1;
      chk("rst_instr", if0.instrBus, 16'h0000);
      chk("rst_din", if0.dataInBus, 16'h0000);
      chk("rst_ready", 16'(if0.ready), 16'd0);
      chk("rst_ready_u1", 16'(if1.ready), 16'd0);
    end
    @(negedge clk);
    drive(0, 5'd0, 16'd0, 16'd0);
    drive(1, 5'd0, 16'd0, 16'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < 16; i++) do_op(0, 2'b10, 1'b0, 1'b0, 16'(i), 16'($urandom));
    // Word write then read
    do_op(0, 2'b10, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
    do_op(0, 2'b01, 1'b0, 1'b0, 16'h0010, 16'h0000);
    chk("t2_din", if0.dataInBus, 16'hBEEF);
    chk("t2_instr", if0.instrBus, 16'h0000);
    // Byte lanes
    do_op(0, 2'b10, 1'b0, 1'b0, 16'h0020, 16'h1234);
    do_op(0, 2'b10, 1'b1, 1'b1, 16'h0020, 16'h00AB);
    do_op(0, 2'b01, 1'b0, 1'b0, 16'h0020, 16'h0000);
    chk("t3_word", if0.dataInBus, 16'hAB34);
    do_op(0, 2'b01, 1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("t3_byte_lo", if0.dataInBus, 16'h0034);
    // Fetch
    do_op(0, 2'b10, 1'b0, 1'b0, 16'h0005, 16'hA5C3);
    do_op(0, 2'b00, 1'b1, 1'b1, 16'h0005, 16'h0000);
    chk("t4_instr", if0.instrBus, 16'hA5C3);
    chk("t4_din", if0.dataInBus, 16'h0034);
    // Out-of-range fetch
    do_op(0, 2'b00, 1'b0, 1'b0, 16'h0010, 16'h0000);
    do_op(0, 2'b00, 1'b0, 1'b0, 16'h0405, 16'h0000);
`ifdef VZ16_BUS_ERR_EN
    chk("t6_instr", if0.instrBus, 16'hDEAD);
`else
    chk("t6_instr", if0.instrBus, 16'hA5C3);
`endif
    // Reset with a pending write request must not touch RAM
    do_op(0, 2'b10, 1'b0, 1'b0, 16'h0040, 16'h7777);
    @(negedge clk);
    rst0 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      drive(0, {2'($urandom), 2'b10, 1'b1}, 16'h0040, 16'($urandom));
      @(posedge clk);
      #1;
      chk("rst2_ready", 16'(if0.ready), 16'd0);
      chk("rst2_instr", if0.instrBus, 16'h0000);
    end
    @(negedge clk);
    drive(0, 5'd0, 16'd0, 16'd0);
    rst0 = 1'b1;
    exp_i[0] = 16'h0000;
    exp_d[0] = 16'h0000;
    do_op(0, 2'b01, 1'b0, 1'b0, 16'h0040, 16'h0000);
    chk("rst2_ram", if0.dataInBus, 16'h7777);
    // Reset during WAIT on the three-wait-state instance
    do_op(1, 2'b10, 1'b0, 1'b0, 16'h0030, 16'h0F0F);
    @(negedge clk);
    drive(1, 5'b00101, 16'h0030, 16'h5555);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("t5_ready_wait", 16'(if1.ready), 16'd0);
    end
    @(negedge clk);
    rst1 = 1'b0;
    drive(1, 5'd0, 16'd0, 16'd0);
    #1;
    chk("t5_din_rst", if1.dataInBus, 16'h0000);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("t5_ready_abort", 16'(if1.ready), 16'd0);
    end
    @(negedge clk);
    rst1 = 1'b1;
    exp_i[1] = 16'h0000;
    exp_d[1] = 16'h0000;
    do_op(1, 2'b01, 1'b0, 1'b0, 16'h0030, 16'h0000);
    chk("t5_ram", if1.dataInBus, 16'h0F0F);
    // Randomized traffic over the pre-filled words, sometimes with upper address bits set
    repeat (60) begin
      logic [15:0] a;
      a = {($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0, 6'd0, 4'($urandom)};
      do_op(0, 2'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
